// File: rtl/logen_pkg.sv
// Shared types and default sizing for the quadrature LO divider.
package logen_pkg;

    typedef enum logic {
        LO_50 = 1'b0,
        LO_25 = 1'b1
    } lo_mode_t;

    localparam int DEF_W_DIV       = 8;
    localparam int DEF_W_TRIM      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int MIN_RATIO       = 2;

endpackage

// File: rtl/ref_edge_sync.sv
// Brings the asynchronous REF into the CKV domain and flags its rising edges.
module ref_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic ckv,
    input  logic rst,
    input  logic ref_in,
    output logic rise
);
    localparam int FW = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ref_dly;
    logic [FW-1:0]          fill_q;
    logic                   armed;

    // fill_q tracks which stages hold real post-reset samples, so a REF that was
    // already high across reset is not mistaken for a fresh rising edge.
    always_ff @(posedge ckv) begin
        if (rst) begin
            sync_q  <= '0;
            ref_dly <= 1'b0;
            fill_q  <= '0;
        end else begin
            sync_q  <= (sync_q << 1) | SYNC_STAGES'(ref_in);
            ref_dly <= sync_q[SYNC_STAGES-1];
            fill_q  <= (fill_q << 1) | FW'(1'b1);
        end
    end

    assign armed = fill_q[SYNC_STAGES];
    assign rise  = armed && sync_q[SYNC_STAGES-1] && !ref_dly;

endmodule

// File: rtl/logen_iq_div.sv
// I/Q LO generator: programmable divide-by-N with 50 % / 25 % quadrature decode
// and a REF-timed snapshot of the LO phase.
module logen_iq_div
    import logen_pkg::*;
#(
    parameter int W_DIV       = DEF_W_DIV,
    parameter int W_TRIM      = DEF_W_TRIM,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              CKV,
    input  logic              RST,
    input  logic              EN,
    input  logic              SYNC,
    input  logic [W_DIV-1:0]  DIV_RATIO,
    input  logic              MODE,
    input  logic [W_TRIM-1:0] PH_TRIM,
    input  logic              REF,
    output logic              LO_I,
    output logic              LO_Q,
    output logic [1:0]        LO_STATE,
    output logic              LO_STATE_VLD
);
    localparam int WX = ((W_DIV > W_TRIM) ? W_DIV : W_TRIM) + 2;
    localparam logic [W_DIV-1:0] NR_MIN = W_DIV'(MIN_RATIO);

    logic [W_DIV-1:0] cnt;
    logic [W_DIV-1:0] nr;
    logic [W_DIV-1:0] ofs;
    lo_mode_t         mode_q;
    logic             load_pend;

    logic [W_DIV-1:0] nr_in;
    logic [W_DIV-1:0] ofs_in;
    logic [WX-1:0]    nr_x;
    logic [WX-1:0]    ofs_sum;
    logic [WX-1:0]    ofs_adj;
    logic [W_DIV-1:0] half;
    logic [W_DIV-1:0] quarter;
    logic [W_DIV-1:0] cq;
    logic             lo_i_nxt;
    logic             lo_q_nxt;
    logic             wrap;
    logic             load;
    logic             restart;
    logic             ref_rise;
    logic             unused_ofs_msbs;

    // Shadow candidates: clamped ratio and the Q offset reduced into 0..Nr-1.
    // A single correction suffices because the trim magnitude stays below Nr.
    always_comb begin
        nr_in   = (DIV_RATIO < NR_MIN) ? NR_MIN : DIV_RATIO;
        nr_x    = WX'(nr_in);
        ofs_sum = WX'(nr_in >> 2) + {{(WX-W_TRIM){PH_TRIM[W_TRIM-1]}}, PH_TRIM};
        if (ofs_sum[WX-1]) begin
            ofs_adj = ofs_sum + nr_x;
        end else if (ofs_sum >= nr_x) begin
            ofs_adj = ofs_sum - nr_x;
        end else begin
            ofs_adj = ofs_sum;
        end
        ofs_in = ofs_adj[W_DIV-1:0];
    end

    assign unused_ofs_msbs = ^ofs_adj[WX-1:W_DIV];

    always_comb begin
        half    = nr >> 1;
        quarter = nr >> 2;
        cq      = (cnt >= ofs) ? (cnt - ofs) : (cnt + (nr - ofs));
        if (mode_q == LO_25) begin
            lo_i_nxt = (cnt >= half) && (cnt < half + quarter);
            lo_q_nxt = (cq >= half) && (cq < half + quarter);
        end else begin
            lo_i_nxt = (cnt >= half);
            lo_q_nxt = (cq >= half);
        end
        wrap    = EN && (cnt == nr - W_DIV'(1));
        load    = load_pend || SYNC || wrap;
        restart = !EN || SYNC || load_pend || wrap;
    end

    // The first post-reset cycle behaves like a phase-align: the shadow set
    // loads and the period starts cleanly from cnt = 0.
    always_ff @(posedge CKV) begin
        if (RST) begin
            cnt       <= '0;
            nr        <= NR_MIN;
            ofs       <= '0;
            mode_q    <= LO_50;
            load_pend <= 1'b1;
            LO_I      <= 1'b0;
            LO_Q      <= 1'b0;
        end else begin
            load_pend <= 1'b0;
            if (load) begin
                nr     <= nr_in;
                ofs    <= ofs_in;
                mode_q <= lo_mode_t'(MODE);
            end
            cnt  <= restart ? '0 : cnt + W_DIV'(1);
            LO_I <= EN && lo_i_nxt;
            LO_Q <= EN && lo_q_nxt;
        end
    end

    ref_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ref_sync (
        .ckv    (CKV),
        .rst    (RST),
        .ref_in (REF),
        .rise   (ref_rise)
    );

    always_ff @(posedge CKV) begin
        if (RST) begin
            LO_STATE     <= 2'b00;
            LO_STATE_VLD <= 1'b0;
        end else begin
            LO_STATE_VLD <= ref_rise;
            if (ref_rise) begin
                LO_STATE <= {LO_I, LO_Q};
            end
        end
    end

endmodule

// File: tb/tb_logen_iq_div.sv
// Self-checking bench for logen_iq_div: waveform tables, corner sequences and a
// randomized run against a cycle-level reference model.
module tb_logen_iq_div;

    localparam int S = 2;

    logic              ckv;
    logic              rst;
    logic              en;
    logic              sync;
    logic [7:0]        div_ratio;
    logic              mode;
    logic signed [3:0] ph_trim;
    logic              ref_sig;
    logic              lo_i;
    logic              lo_q;
    logic [1:0]        lo_state;
    logic              lo_state_vld;

    int checks = 0;
    int errors = 0;

    int m_cnt, m_nr, m_mode, m_ofs, m_pend;
    int m_i, m_q, m_state, m_vld;
    int ref_hist[$];

    typedef struct {
        string      name;
        int         div;
        int         md;
        int         trim;
        int         n;
        logic [15:0] exp_i;
        logic [15:0] exp_q;
    } vec_t;

    vec_t vecs[7];

    logen_iq_div #(
        .W_DIV       (8),
        .W_TRIM      (4),
        .SYNC_STAGES (S)
    ) dut (
        .CKV          (ckv),
        .RST          (rst),
        .EN           (en),
        .SYNC         (sync),
        .DIV_RATIO    (div_ratio),
        .MODE         (mode),
        .PH_TRIM      (ph_trim),
        .REF          (ref_sig),
        .LO_I         (lo_i),
        .LO_Q         (lo_q),
        .LO_STATE     (lo_state),
        .LO_STATE_VLD (lo_state_vld)
    );

    initial begin
        ckv = 1'b0;
        forever #5 ckv = ~ckv;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Reference model, advanced once per CKV edge from the rules of the block:
    // REF history gives the edge detector, modular arithmetic gives the phases.
    task automatic modelEdge();
        int h, qw, cq, ni, nq, n, trim, sz;
        bit wrap;
        if (rst) begin
            m_cnt = 0; m_nr = 2; m_mode = 0; m_ofs = 0; m_pend = 1;
            m_i = 0; m_q = 0; m_state = 0; m_vld = 0;
            ref_hist.delete();
        end else begin
            sz = ref_hist.size();
            m_vld = 0;
            if (sz >= S + 1 && ref_hist[sz-S] == 1 && ref_hist[sz-S-1] == 0) begin
                m_vld = 1;
                m_state = m_i * 2 + m_q;
            end
            ref_hist.push_back(int'(ref_sig));
            if (ref_hist.size() > S + 4) void'(ref_hist.pop_front());

            h  = m_nr / 2;
            qw = m_nr / 4;
            cq = ((m_cnt - m_ofs) % m_nr + m_nr) % m_nr;
            if (m_mode == 0) begin
                ni = int'(m_cnt >= h);
                nq = int'(cq >= h);
            end else begin
                ni = int'(m_cnt >= h && m_cnt < h + qw);
                nq = int'(cq >= h && cq < h + qw);
            end
            wrap = en && (m_cnt == m_nr - 1);
            if (m_pend != 0 || sync || wrap) begin
                n = (div_ratio < 2) ? 2 : int'(div_ratio);
                trim = int'(ph_trim);
                m_nr = n;
                m_mode = int'(mode);
                m_ofs = ((n / 4 + trim) % n + n) % n;
            end
            m_cnt = (!en || sync || m_pend != 0 || wrap) ? 0 : m_cnt + 1;
            m_pend = 0;
            m_i = en ? ni : 0;
            m_q = en ? nq : 0;
        end
    endtask

    task automatic tick();
        @(posedge ckv);
        modelEdge();
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit e, input bit s, input int d, input bit m, input int t);
        en        = e;
        sync      = s;
        div_ratio = 8'(d);
        mode      = m;
        ph_trim   = 4'(t);
    endtask

    task automatic checkPattern(input string name, input int n, input logic [15:0] ei,
                                input logic [15:0] eq, input int k0, input int count);
        for (int k = k0; k < k0 + count; k++) begin
            tick();
            checkOutput({name, "_i"}, int'(lo_i), int'(ei[k % n]));
            checkOutput({name, "_q"}, int'(lo_q), int'(eq[k % n]));
        end
    endtask

    task automatic syncTo(input int d, input bit m, input int t);
        applyStimulus(1'b1, 1'b1, d, m, t);
        tick();
        sync = 1'b0;
    endtask

    task automatic pickConfig();
        int d, n, lo, hi;
        d  = $urandom_range(0, 20);
        n  = (d < 2) ? 2 : d;
        lo = (-(n - 1) < -8) ? -8 : -(n - 1);
        hi = (n - 1 > 7) ? 7 : n - 1;
        div_ratio = 8'(d);
        ph_trim   = 4'(lo + int'($urandom_range(0, hi - lo)));
        mode      = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int exp_state;

        vecs[0] = '{"n8_m0",   8, 0,  0,  8, 16'h00F0, 16'h00C3};
        vecs[1] = '{"n5_m0",   5, 0,  0,  5, 16'h001C, 16'h0019};
        vecs[2] = '{"n8_m1",   8, 1,  0,  8, 16'h0030, 16'h00C0};
        vecs[3] = '{"n8_tm1",  8, 0, -1,  8, 16'h00F0, 16'h00E1};
        vecs[4] = '{"n1_clamp",1, 0,  0,  2, 16'h0002, 16'h0002};
        vecs[5] = '{"n12_m1", 12, 1,  3, 12, 16'h01C0, 16'h0007};
        vecs[6] = '{"n3_t1",   3, 0,  1,  3, 16'h0006, 16'h0005};

        rst = 1'b1;
        ref_sig = 1'b0;
        applyStimulus(1'b1, 1'b0, 8, 1'b0, 0);
        repeat (3) tick();
        checkOutput("rst_lo_i", int'(lo_i), 0);
        checkOutput("rst_lo_q", int'(lo_q), 0);
        checkOutput("rst_state", int'(lo_state), 0);
        checkOutput("rst_vld", int'(lo_state_vld), 0);
        rst = 1'b0;

        foreach (vecs[v]) begin
            syncTo(vecs[v].div, 1'(vecs[v].md), vecs[v].trim);
            checkPattern(vecs[v].name, vecs[v].n, vecs[v].exp_i, vecs[v].exp_q, 0, 2 * vecs[v].n);
        end

        // ratio change mid-period only takes effect at the wrap
        syncTo(8, 1'b0, 0);
        checkPattern("ratio8", 8, 16'h00F0, 16'h00C3, 0, 3);
        div_ratio = 8'd12;
        checkPattern("ratio8", 8, 16'h00F0, 16'h00C3, 3, 5);
        checkPattern("ratio12", 12, 16'h0FC0, 16'h0E07, 0, 12);

        // SYNC at cnt=5, then EN dropped mid-period and restored
        syncTo(8, 1'b0, 0);
        checkPattern("pre_sync", 8, 16'h00F0, 16'h00C3, 0, 5);
        sync = 1'b1;
        checkPattern("at_sync", 8, 16'h00F0, 16'h00C3, 5, 1);
        sync = 1'b0;
        checkPattern("post_sync", 8, 16'h00F0, 16'h00C3, 0, 3);
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("en_low_i", int'(lo_i), 0);
            checkOutput("en_low_q", int'(lo_q), 0);
        end
        en = 1'b1;
        checkPattern("en_resume", 8, 16'h00F0, 16'h00C3, 0, 8);

        // reset mid-period leaves no partial pulse
        syncTo(8, 1'b0, 0);
        checkPattern("pre_rst", 8, 16'h00F0, 16'h00C3, 0, 5);
        rst = 1'b1;
        tick();
        checkOutput("midrst_i", int'(lo_i), 0);
        checkOutput("midrst_q", int'(lo_q), 0);
        rst = 1'b0;
        tick();
        checkOutput("rst_rel_i", int'(lo_i), 0);
        checkOutput("rst_rel_q", int'(lo_q), 0);
        checkPattern("post_rst", 8, 16'h00F0, 16'h00C3, 0, 8);

        // REF step: strobe three edges later carrying that cycle's LO
        ref_sig = 1'b1;
        tick();
        checkOutput("ref_e1_vld", int'(lo_state_vld), 0);
        tick();
        checkOutput("ref_e2_vld", int'(lo_state_vld), 0);
        exp_state = m_i * 2 + m_q;
        tick();
        checkOutput("ref_e3_vld", int'(lo_state_vld), 1);
        checkOutput("ref_e3_state", int'(lo_state), exp_state);
        tick();
        checkOutput("ref_e4_vld", int'(lo_state_vld), 0);

        // reset while REF is high: nothing until a genuine new rising edge
        rst = 1'b1;
        repeat (2) tick();
        checkOutput("rsthi_state", int'(lo_state), 0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("rsthi_vld", int'(lo_state_vld), 0);
        end
        ref_sig = 1'b0;
        repeat (4) tick();
        ref_sig = 1'b1;
        repeat (2) tick();
        checkOutput("rsthi_e2_vld", int'(lo_state_vld), 0);
        tick();
        checkOutput("rsthi_e3_vld", int'(lo_state_vld), 1);

        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 299) == 0);
            sync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) pickConfig();
            if ($urandom_range(0, 5) == 0) ref_sig = ~ref_sig;
            tick();
            checkOutput("rnd_lo_i", int'(lo_i), m_i);
            checkOutput("rnd_lo_q", int'(lo_q), m_q);
            checkOutput("rnd_vld", int'(lo_state_vld), m_vld);
            checkOutput("rnd_state", int'(lo_state), m_state);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logen_iq_div.md
LOGEN_IQ_DIV -- requirements
Module: logen_iq_div

Interface
REQ-001 Parameter W_DIV, default 8: width of the divide-ratio input and the phase counter.
REQ-002 Parameter W_TRIM, default 4: width of the signed Q-phase trim input.
REQ-003 Parameter SYNC_STAGES, default 2: number of REF synchroniser flops ahead of the edge detector.
REQ-004 CKV  in  1  single clock (VCO/divided carrier); every flop in the block is clocked on posedge CKV.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 EN  in  1  divider enable.
REQ-007 SYNC  in  1  phase-align request: forces the counter to 0.
REQ-008 DIV_RATIO  in  W_DIV  divide ratio N; legal 2..2^W_DIV-1.
REQ-009 MODE  in  1  0 = 50 % duty I/Q, 1 = 25 % duty I/Q.
REQ-010 PH_TRIM  in  W_TRIM  signed Q-phase trim in CKV cycles.
REQ-011 REF  in  1  reference, asynchronous to CKV; sampled as data.
REQ-012 LO_I / LO_Q  out  1 each  registered in-phase / quadrature LO.
REQ-013 LO_STATE  out  2  {LO_I, LO_Q} captured at the detected REF rising edge.
REQ-014 LO_STATE_VLD  out  1  one-cycle strobe marking each LO_STATE update.

Function
REQ-015 The counter cnt shall run 0..Nr-1 and wrap to 0, where Nr is the shadow divide ratio.
REQ-016 Nr, MODE and the Q offset OFS shall load from the inputs only when cnt wraps, SYNC is asserted, or the cycle after reset; mid-period input changes shall have no effect until then.
REQ-017 DIV_RATIO values below 2 shall load as Nr = 2.
REQ-018 Let H = floor(Nr/2) and Qw = floor(Nr/4). OFS = (Qw + PH_TRIM) mod Nr, evaluated at load time; the result shall be in 0..Nr-1 for any |PH_TRIM| < Nr.
REQ-019 Let cq = (cnt - OFS) mod Nr.
REQ-020 MODE 0: next LO_I = (cnt >= H) and next LO_Q = (cq >= H). For odd Nr this gives a low phase of floor(Nr/2) cycles and a high phase of ceil(Nr/2) cycles.
REQ-021 MODE 1: next LO_I = (H <= cnt < H+Qw) and next LO_Q = (H <= cq < H+Qw).
REQ-022 LO_I and LO_Q shall be registered, one CKV cycle after the cnt value that produces them.
REQ-023 SYNC high: cnt shall be 0 on the next cycle. SYNC has priority over wrap and increment.
REQ-024 EN low: cnt shall be held at 0 and LO_I/LO_Q driven 0 on the next cycle. EN rising resumes from cnt = 0.
REQ-025 EN low shall take priority over SYNC.
REQ-026 REF shall pass through SYNC_STAGES flops. A rising edge is detected when the last stage is 1 and the one-cycle-delayed copy is 0.
REQ-027 On a detected edge, LO_STATE shall capture the current registered {LO_I, LO_Q} and LO_STATE_VLD shall pulse high for exactly one cycle.
REQ-028 Otherwise LO_STATE shall hold its value and LO_STATE_VLD shall be 0.
REQ-029 The sampler shall operate regardless of EN.

Reset
REQ-030 During RST, the following shall be 0: cnt, LO_I, LO_Q, LO_STATE, LO_STATE_VLD and all REF sync flops.
REQ-031 During RST, Nr shall be 2 and MODE 0.
REQ-032 The first post-reset cycle shall load the shadow registers from the inputs.
REQ-033 RST asserted mid-period shall abort the period with no partial pulse afterwards.

Structure
REQ-034 Package logen_pkg shall hold the MODE enum (LO_50, LO_25), the default W_DIV/W_TRIM/SYNC_STAGES constants and the minimum ratio (2).
REQ-035 The REF synchroniser and edge detector shall be a sub-module named ref_edge_sync, parameterised by SYNC_STAGES.
REQ-036 The divider, offset arithmetic and waveform decode shall remain in logen_iq_div.

Verification
REQ-037 N=8, MODE 0, trim 0: LO_I = 0000_1111 repeating; LO_Q lags by 2 cycles; period 8.
REQ-038 N=5, MODE 0: LO_I low for 2 cycles and high for 3; OFS=1.
REQ-039 N=8, MODE 1: LO_I high only for cnt=4,5; LO_Q high only for cnt=6,7.
REQ-040 N=8, PH_TRIM=-1: OFS=1; LO_Q lags LO_I by 1 cycle.
REQ-041 DIV_RATIO changed 8->12 at cnt=3: the current period completes at 8 and the next period is 12.
REQ-042 SYNC asserted at cnt=5, then EN deasserted mid-period: cnt is 0 on the next cycle; outputs 0 while EN is low; resume from cnt=0.
REQ-043 REF stepped 0->1 with SYNC_STAGES=2: LO_STATE_VLD pulses once, 3 CKV edges later; LO_STATE equals {LO_I, LO_Q} of that cycle.
REQ-044 RST asserted with REF high: no VLD pulse until the next REF rising edge.
